// File: rtl/key_led_pkg.sv
// key_led_pkg: shared mode encoding for the key-driven LED controller.
package key_led_pkg;

  localparam int MODE_W = 2;

  // 2'b11 is deliberately left unnamed; the FSM treats it as illegal.
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10
  } mode_t;

endpackage

// File: rtl/key_led_ctrl_debounce.sv
// key_debounce: two-flop synchroniser, level debouncer and press-event
// generator for an active-low board key.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_stable,
  output logic key_flag
);

  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CNT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_flag;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_accept;

  assign w_diff   = (r_sync2 != r_stable);
  assign w_accept = w_diff && (r_cnt == TERM);

  // Synchronise, count how long the new level has held, accept it at terminal
  // count and flag only the released-to-pressed (1->0) transition.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_flag   <= 1'b0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_flag <= w_accept && !r_sync2;
    end
  end

  assign key_stable = r_stable;
  assign key_flag   = r_flag;

endmodule

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: debounced key steps the LED through OFF -> ON -> BLINK -> OFF.
// Optional feature macro: KEY_LONG_PRESS_EN (holding the key LONG_CNT cycles
// forces the mode back to OFF once per hold).
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 999_999,
  parameter int BLINK_CNT    = 24_999_999,
  parameter int LONG_CNT     = 99_999_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              key_in,
  output logic              led_out,
  output logic [MODE_W-1:0] mode,
  output logic              key_flag
);

  localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
  localparam logic [BW-1:0] BTERM = BW'(BLINK_CNT - 1);

  mode_t         r_mode;
  mode_t         w_mode_nxt;
  logic          r_led;
  logic          w_led_nxt;
  logic [BW-1:0] r_blink;
  logic [BW-1:0] w_blink_nxt;
  logic          w_key_stable;
  logic          w_key_flag;
  logic          w_long_fire;

  key_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_deb (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_in    (key_in),
    .key_stable(w_key_stable),
    .key_flag  (w_key_flag)
  );

`ifdef KEY_LONG_PRESS_EN
  localparam int LCW = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;
  localparam logic [LCW-1:0] LTERM = LCW'(LONG_CNT - 1);

  logic [LCW-1:0] r_hold;
  logic           r_hold_done;

  assign w_long_fire = !w_key_stable && (r_hold == LTERM) && !r_hold_done;

  // Measure the current hold; saturate at terminal count and fire once per hold.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || w_key_stable) begin
      r_hold      <= '0;
      r_hold_done <= 1'b0;
    end else begin
      if (r_hold != LTERM) r_hold <= r_hold + 1'b1;
      if (w_long_fire) r_hold_done <= 1'b1;
    end
  end
`else
  // Hold logic compiled out; stable level and LONG_CNT are intentionally unused.
  logic w_unused;
  assign w_unused    = ^{w_key_stable, LONG_CNT[0]};
  assign w_long_fire = 1'b0;
`endif

  // Mode, LED and blink counter registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_mode  <= MODE_OFF;
      r_led   <= 1'b0;
      r_blink <= '0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_led   <= w_led_nxt;
      r_blink <= w_blink_nxt;
    end
  end

  // Next mode and LED drive; the blink counter only runs while in BLINK.
  always_comb begin
    w_mode_nxt  = r_mode;
    w_led_nxt   = r_led;
    w_blink_nxt = '0;
    case (r_mode)
      MODE_OFF: begin
        w_led_nxt = 1'b0;
        if (w_key_flag) begin
          w_mode_nxt = MODE_ON;
          w_led_nxt  = 1'b1;
        end
      end
      MODE_ON: begin
        w_led_nxt = 1'b1;
        if (w_key_flag) begin
          w_mode_nxt = MODE_BLINK;
          w_led_nxt  = 1'b1;
        end
      end
      MODE_BLINK: begin
        if (w_key_flag) begin
          w_mode_nxt = MODE_OFF;
          w_led_nxt  = 1'b0;
        end else if (r_blink == BTERM) begin
          w_led_nxt = ~r_led;
        end else begin
          w_blink_nxt = r_blink + 1'b1;
        end
      end
      default: begin
        w_mode_nxt = MODE_OFF;
        w_led_nxt  = 1'b0;
      end
    endcase
    if (w_long_fire) begin
      w_mode_nxt  = MODE_OFF;
      w_led_nxt   = 1'b0;
      w_blink_nxt = '0;
    end
  end

  assign led_out  = r_led;
  assign mode     = r_mode;
  assign key_flag = w_key_flag;

endmodule

// File: tb/tb_key_led_ctrl.sv
// tb_key_led_ctrl: directed scenarios plus random key activity, checked every
// cycle against an event-level model of the key/LED behaviour.
module tb_key_led_ctrl;

  localparam int D = 4;
  localparam int B = 3;
  localparam int L = 16;
`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_EXP = 0;
`else
  localparam int LONG_EXP = 1;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_in  = 1'b1;
  logic       led_out;
  logic [1:0] mode;
  logic       key_flag;

  always #5 sys_clk = ~sys_clk;

  key_led_ctrl #(
    .DEBOUNCE_CNT(D),
    .BLINK_CNT   (B),
    .LONG_CNT    (L)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key_in  (key_in),
    .led_out (led_out),
    .mode    (mode),
    .key_flag(key_flag)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: the accepted level flips once the last D synchronised samples all
  // disagree with it; modes rotate on press events; BLINK phase is arithmetic
  // on the cycles spent in BLINK.
  bit q[$];
  bit m_stable, m_flag, m_led;
  int m_mode, m_t, m_held;

  // Observation bookkeeping for the directed checks.
  int       flag_cnt = 0;
  int       last_flag_cyc = -1;
  int       mode_chg_cyc = -1;
  logic [1:0] prev_mode = 2'd0;
  logic     prev_led = 1'b0;
  int       b_idx = 0;
  int       b_seq[7];
  int       blink_exp[7] = '{1, 1, 1, 0, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit rst, input bit kin);
    bit acc;
    bit old_stable;
    bit old_flag;
    bit new_flag;
    bit fire;
    if (rst) begin
      q.delete();
      repeat (D + 2) q.push_back(1'b1);
      m_stable = 1'b1;
      m_flag   = 1'b0;
      m_mode   = 0;
      m_led    = 1'b0;
      m_t      = 0;
      m_held   = 0;
      return;
    end
    acc = 1'b1;
    for (int j = 0; j < D; j++)
      if (q[q.size() - 2 - j] == m_stable) acc = 1'b0;
    old_stable = m_stable;
    old_flag   = m_flag;
    new_flag   = acc && m_stable;
    if (acc) m_stable = ~m_stable;
    fire = 1'b0;
`ifdef KEY_LONG_PRESS_EN
    if (!old_stable) begin
      m_held++;
      fire = (m_held == L);
    end else begin
      m_held = 0;
    end
`else
    m_held = old_stable ? 0 : m_held + 1;
`endif
    if (old_flag) begin
      m_mode = (m_mode + 1) % 3;
      m_t    = 0;
    end else if (m_mode == 2) begin
      m_t++;
    end
    if (fire) m_mode = 0;
    m_led  = (m_mode == 0) ? 1'b0 : (m_mode == 1) ? 1'b1 : (((m_t / B) % 2) == 0);
    m_flag = new_flag;
    q.push_back(kin);
    if (q.size() > D + 4) void'(q.pop_front());
  endtask

  task automatic step(input bit rst, input bit kin);
    sys_rst = rst;
    key_in  = kin;
    @(posedge sys_clk);
    model_edge(rst, kin);
    cyc++;
    @(negedge sys_clk);
    chk("key_flag", key_flag, m_flag);
    chk("mode", mode, m_mode);
    chk("led_out", led_out, m_led);
    if (key_flag === 1'b1) begin
      flag_cnt++;
      last_flag_cyc = cyc;
    end
    if (mode !== prev_mode) mode_chg_cyc = cyc;
    if (mode === 2'd2) begin
      if (b_idx < 7) b_seq[b_idx++] = led_out;
    end else begin
      b_idx = 0;
    end
    prev_mode = mode;
    prev_led  = led_out;
  endtask

  task automatic press(input int hold, input int rel);
    repeat (hold) step(0, 0);
    repeat (rel) step(0, 1);
  endtask

  initial begin
    int f0;
    int k;
    int len;
    bit lvl;
    bit found;

    // Reset with the key already pressed, then exactly one flag after release.
    step(1, 0);
    step(1, 0);
    chk("rst_mode", mode, 0);
    chk("rst_led", led_out, 0);
    chk("rst_flag", key_flag, 0);
    f0 = flag_cnt;
    press(12, 10);
    chk("rst_release_one_flag", flag_cnt - f0, 1);

    // Bounce shorter than the debounce window.
    step(1, 1);
    step(1, 1);
    repeat (3) step(0, 1);
    f0 = flag_cnt;
    press(3, 8);
    chk("bounce_no_flag", flag_cnt - f0, 0);
    chk("bounce_mode", mode, 0);

    // Clean press: flag at k+5, mode/LED at k+6, release gives no flag.
    f0 = flag_cnt;
    k  = cyc + 1;
    repeat (10) step(0, 0);
    chk("press_flag_edge", last_flag_cyc - k, 5);
    chk("press_mode_edge", mode_chg_cyc - k, 6);
    chk("press_mode_on", mode, 1);
    chk("press_led_on", led_out, 1);
    repeat (10) step(0, 1);
    chk("press_release_flags", flag_cnt - f0, 1);

    // ON -> BLINK, capture the LED pattern from the mode change.
    press(8, 12);
    chk("blink_mode", mode, 2);
    for (int i = 0; i < 7; i++) chk("blink_seq", b_seq[i], blink_exp[i]);

    // Reset mid-blink while LED is low and the debouncer is mid-count.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, 1);
      if (led_out === 1'b1 && prev_mode === 2'd2 && b_idx == 7) begin
        found = (m_t % B) == 0;
      end
    end
    chk("blink_rise_found", found, 1);
    repeat (3) step(0, 0);
    chk("pre_rst_mode", mode, 2);
    chk("pre_rst_led", led_out, 0);
    step(1, 0);
    chk("midrst_mode", mode, 0);
    chk("midrst_led", led_out, 0);
    chk("midrst_blink_cnt", dut.r_blink, 0);
    chk("midrst_deb_cnt", dut.u_deb.r_cnt, 0);
    repeat (8) step(0, 1);

    // BLINK -> OFF returns the LED to 0 immediately.
    press(8, 6);
    press(8, 6);
    chk("blink_entry2", mode, 2);
    press(6, 0);
    step(0, 0);
    chk("blink_exit_mode", mode, 0);
    chk("blink_exit_led", led_out, 0);
    repeat (10) step(0, 1);

    // Long press from OFF.
    step(1, 1);
    repeat (3) step(0, 1);
    k = cyc + 1;
    repeat (7) step(0, 0);
    chk("long_mode_on", mode, 1);
    repeat (18) step(0, 0);
    chk("long_mode_end", mode, LONG_EXP);
    repeat (10) step(0, 1);

    // Random key activity with occasional resets and long holds.
    lvl = 1'b1;
    for (int s = 0; s < 400; s++) begin
      lvl = ~lvl;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 7);
      if ($urandom_range(0, 59) == 0) step(1, lvl);
      repeat (len) step(0, lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_led_ctrl.md
# key_led_ctrl

Key-driven LED mode controller sequencing the key-capture/LED-drive path of the flip-flop lab. It synchronises and debounces the raw board key, converts each press into a one-cycle event, and steps a mode state machine that drives the LED: off, steady on, or blinking. It sits between the board key pin and the LED pin, replacing a direct key-to-LED register.

## Interface
- DEBOUNCE_CNT, 999_999: consecutive cycles a changed key level must hold before acceptance (20 ms at 50 MHz)
- BLINK_CNT, 24_999_999: cycles per LED half-period in BLINK mode
- LONG_CNT, 99_999_999: held-press cycles for long-press detection (used only with KEY_LONG_PRESS_EN)
- sys_clk  in  1  system clock, all logic rising-edge
- sys_rst  in  1  reset, synchronous, active-high
- key_in  in  1  raw asynchronous key, pressed = 0
- led_out  out  1  LED drive, 1 = lit
- mode  out  2  current mode: 00 OFF, 01 ON, 10 BLINK (11 never driven)
- key_flag  out  1  one-cycle pulse per debounced press

## Operation
- Reset values: led_out=0, mode=00, key_flag=0; synchroniser flops and stable key=1; all counters 0.
- Synchroniser: two flops on key_in; only the second-stage output (key_sync) is used.
- Debounce: counter cleared whenever key_sync equals stable key; otherwise it increments. When counter==DEBOUNCE_CNT-1 and key_sync still differs: stable key <= key_sync, counter <= 0.
- Any bounce shorter than DEBOUNCE_CNT cycles clears the counter; no level change, no flag.
- key_flag: registered, high for exactly one cycle, in the cycle after stable key changes 1->0. Release (0->1) produces no flag.
- Mode FSM, advances only on key_flag: OFF->ON->BLINK->OFF. 11 is illegal; recovery to OFF on the next clock.
- led_out: OFF 0; ON 1; BLINK toggles each time the blink counter reaches BLINK_CNT-1 (counter then wraps to 0).
- Entering BLINK: blink counter <= 0, led_out <= 1. Leaving BLINK: blink counter held at 0.
- Counter widths: $clog2 of the respective parameter; no counter passes its terminal value.

## Timing
- Edge k first samples key_in=0 and the press is clean: key_sync=0 after edge k+1; stable key and key_flag update at edge k+DEBOUNCE_CNT+1.
- mode and led_out update at edge k+DEBOUNCE_CNT+2.
- BLINK: led_out period = 2*BLINK_CNT cycles, first toggle BLINK_CNT cycles after mode becomes 10.
- sys_rst has priority over all events. Asserted mid-debounce or mid-blink, every register takes its reset value at that edge. A key held across reset release is debounced afresh from stable key=1 and yields one flag.
- Press arriving while already in BLINK: mode 00 and led_out 0 at the same edge; no partial blink is completed.

## Configuration
- KEY_LONG_PRESS_EN defined: a hold counter runs while stable key=0 and clears on release. At count LONG_CNT-1, mode <= OFF and led_out <= 0 once per hold; the hold counter then saturates. The short-press flag at press start still advances the mode normally.
- Undefined: no hold counter is present, hold duration has no effect, and the ports are unchanged.

## Structure
- Package key_led_pkg: 2-bit mode constants MODE_OFF, MODE_ON, MODE_BLINK, and the mode typedef.
- Sub-module key_debounce (parameter DEBOUNCE_CNT): synchroniser, debounce counter, stable key, and the key_flag generator. The top holds the FSM, blink counter and optional long-press logic.

## Test plan
Bench parameters: DEBOUNCE_CNT=4, BLINK_CNT=3, LONG_CNT=16.
- Reset: sys_rst=1 for 2 cycles with key_in=0 -> led_out=0, mode=00, key_flag=0; after release, exactly one key_flag.
- Bounce: key_in=0 for 3 cycles, then 1 -> no key_flag, mode stays 00.
- Clean press: key_in=0 held 10 cycles -> key_flag high exactly one cycle, at edge k+5. mode=01 and led_out=1 at edge k+6. Release produces no flag.
- Mode cycle: 3 clean presses -> mode 00->01->10->00. In BLINK, led_out=1,1,1,0,0,0,1,... from mode=10; returns to 0 on leaving BLINK.
- Mid-operation reset: sys_rst pulsed one cycle while in BLINK with led_out=0 -> mode=00, led_out=0, blink and debounce counters 0 at that edge.
- Long press: with KEY_LONG_PRESS_EN, press from OFF and hold 25 cycles -> mode 01, then 00 after 16 held cycles. Without the macro, mode stays 01.
